alu_exec_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_ctl_decode.sv | 82 ++++++++
 rtl/alu_exec_unit.sv | 89 ++++++++
 tb/tb_alu_exec_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the sail execute-stage ALU:
// opcodes, ALU operation codes and branch conditions.
package alu_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        OP_AND    = 4'b0000,
        OP_OR     = 4'b0001,
        OP_ADD    = 4'b0010,
        OP_SRL    = 4'b0011,
        OP_SRA    = 4'b0100,
        OP_SLL    = 4'b0101,
        OP_SUB    = 4'b0110,
        OP_SLT    = 4'b0111,
        OP_XOR    = 4'b1000,
        OP_SLTU   = 4'b1001,
        OP_PASS_B = 4'b1010
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_EQ   = 3'b001,
        BR_NE   = 3'b010,
        BR_LT   = 3'b011,
        BR_GE   = 3'b100,
        BR_LTU  = 3'b101,
        BR_GEU  = 3'b110
    } br_cond_e;

endpackage

// File: rtl/alu_ctl_decode.sv
// Opcode/FuncCode to 7-bit ALU control word {branch[2:0], op[3:0]}.
// Purely combinational.
module alu_ctl_decode
    import alu_pkg::*;
(
    input  logic [6:0] Opcode,
    input  logic [3:0] FuncCode,
    output logic [6:0] ALUCtl
);

    alu_op_e  op;
    br_cond_e br;
    logic     is_r;
    logic     is_i;
    logic     is_add;
    logic     is_lui;
    logic     is_br;

    assign is_r   = (Opcode == OPC_R);
    assign is_i   = (Opcode == OPC_I);
    assign is_lui = (Opcode == OPC_LUI);
    assign is_br  = (Opcode == OPC_BRANCH);
    assign is_add = (Opcode == OPC_LOAD) || (Opcode == OPC_STORE) ||
                    (Opcode == OPC_AUIPC) || (Opcode == OPC_JAL) ||
                    (Opcode == OPC_JALR);

    always_comb begin
        op = OP_ADD;
        br = BR_NONE;
        unique case (1'b1)
            is_r: begin
                case (FuncCode)
                    4'b0000: op = OP_ADD;
                    4'b1000: op = OP_SUB;
                    4'b0001: op = OP_SLL;
                    4'b0010: op = OP_SLT;
                    4'b0011: op = OP_SLTU;
                    4'b0100: op = OP_XOR;
                    4'b0101: op = OP_SRL;
                    4'b1101: op = OP_SRA;
                    4'b0110: op = OP_OR;
                    4'b0111: op = OP_AND;
                    default: op = OP_ADD;
                endcase
            end
            // Immediate forms ignore instr[30] except to pick SRA over SRL.
            is_i: begin
                case (FuncCode[2:0])
                    3'b000:  op = OP_ADD;
                    3'b001:  op = OP_SLL;
                    3'b010:  op = OP_SLT;
                    3'b011:  op = OP_SLTU;
                    3'b100:  op = OP_XOR;
                    3'b101:  op = FuncCode[3] ? OP_SRA : OP_SRL;
                    3'b110:  op = OP_OR;
                    default: op = OP_AND;
                endcase
            end
            is_add: op = OP_ADD;
            is_lui: op = OP_PASS_B;
            is_br: begin
                op = OP_SUB;
                case (FuncCode[2:0])
                    3'b000:  br = BR_EQ;
                    3'b001:  br = BR_NE;
                    3'b100:  br = BR_LT;
                    3'b101:  br = BR_GE;
                    3'b110:  br = BR_LTU;
                    3'b111:  br = BR_GEU;
                    default: br = BR_NONE;
                endcase
            end
            default: begin
                op = OP_ADD;
                br = BR_NONE;
            end
        endcase
    end

    assign ALUCtl = {br, op};

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with MEM/WB operand forwarding and
// registered result / branch-taken outputs.
module alu_exec_unit
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  FuncCode,
    input  logic [6:0]  Opcode,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] MEM_result,
    input  logic [31:0] WB_result,
    input  logic        MEM_fwd1_reg,
    input  logic        WB_fwd1_reg,
    input  logic        MEM_fwd2_reg,
    input  logic        WB_fwd2_reg,
    output logic [6:0]  ALUCtl,
    output logic [31:0] ALUOut,
    output logic        Branch_Enable
);

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] result;
    logic        taken;
    logic [3:0]  op;
    logic [2:0]  br;
    logic [4:0]  shamt;

    alu_ctl_decode u_dec (
        .Opcode   (Opcode),
        .FuncCode (FuncCode),
        .ALUCtl   (ALUCtl)
    );

    assign op = ALUCtl[3:0];
    assign br = ALUCtl[6:4];

    // MEM holds the younger value, so it wins over WB.
    assign op_a = MEM_fwd1_reg ? MEM_result :
                  WB_fwd1_reg  ? WB_result  : A;
    assign op_b = MEM_fwd2_reg ? MEM_result :
                  WB_fwd2_reg  ? WB_result  : B;

    assign shamt = op_b[4:0];

    always_comb begin
        result = 32'd0;
        case (op)
            OP_AND:    result = op_a & op_b;
            OP_OR:     result = op_a | op_b;
            OP_ADD:    result = op_a + op_b;
            OP_SRL:    result = op_a >> shamt;
            OP_SRA:    result = $signed(op_a) >>> shamt;
            OP_SLL:    result = op_a << shamt;
            OP_SUB:    result = op_a - op_b;
            OP_SLT:    result = {31'd0, $signed(op_a) < $signed(op_b)};
            OP_XOR:    result = op_a ^ op_b;
            OP_SLTU:   result = {31'd0, op_a < op_b};
            OP_PASS_B: result = op_b;
            default:   result = 32'd0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (br)
            BR_EQ:   taken = (op_a == op_b);
            BR_NE:   taken = (op_a != op_b);
            BR_LT:   taken = ($signed(op_a) < $signed(op_b));
            BR_GE:   taken = ($signed(op_a) >= $signed(op_b));
            BR_LTU:  taken = (op_a < op_b);
            BR_GEU:  taken = (op_a >= op_b);
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ALUOut        <= 32'd0;
            Branch_Enable <= 1'b0;
        end else begin
            ALUOut        <= result;
            Branch_Enable <= taken;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit.
// Inputs change 1ns after a rising edge; outputs checked 1ns after the next.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  FuncCode;
    logic [6:0]  Opcode;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] MEM_result;
    logic [31:0] WB_result;
    logic        MEM_fwd1_reg;
    logic        WB_fwd1_reg;
    logic        MEM_fwd2_reg;
    logic        WB_fwd2_reg;
    logic [6:0]  ALUCtl;
    logic [31:0] ALUOut;
    logic        Branch_Enable;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] I   = 7'b0010011;
    localparam logic [6:0] BRN = 7'b1100011;
    localparam logic [6:0] LUI = 7'b0110111;

    alu_exec_unit dut (
        .clk           (clk),
        .rst           (rst),
        .FuncCode      (FuncCode),
        .Opcode        (Opcode),
        .A             (A),
        .B             (B),
        .MEM_result    (MEM_result),
        .WB_result     (WB_result),
        .MEM_fwd1_reg  (MEM_fwd1_reg),
        .WB_fwd1_reg   (WB_fwd1_reg),
        .MEM_fwd2_reg  (MEM_fwd2_reg),
        .WB_fwd2_reg   (WB_fwd2_reg),
        .ALUCtl        (ALUCtl),
        .ALUOut        (ALUOut),
        .Branch_Enable (Branch_Enable)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [6:0] opc, input logic [3:0] fc,
                       input logic [31:0] a, input logic [31:0] b);
        Opcode   = opc;
        FuncCode = fc;
        A        = a;
        B        = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b0;
        Opcode       = R;
        FuncCode     = 4'b0000;
        A            = 32'd5;
        B            = 32'd3;
        MEM_result   = 32'd100;
        WB_result    = 32'd200;
        MEM_fwd1_reg = 1'b0;
        WB_fwd1_reg  = 1'b0;
        MEM_fwd2_reg = 1'b0;
        WB_fwd2_reg  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out", ALUOut, 32'd0);
        check("reset_br", {31'd0, Branch_Enable}, 32'd0);

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_add", ALUOut, 32'd8);

        run(R, 4'b0111, 32'h0F, 32'h55);
        check("r_and", ALUOut, 32'h05);
        run(R, 4'b0110, 32'h0F, 32'h55);
        check("r_or", ALUOut, 32'h5F);
        run(R, 4'b0000, 32'd10000, 32'd7);
        check("r_add", ALUOut, 32'd10007);
        run(R, 4'b1000, 32'd10000, 32'd7);
        check("r_sub", ALUOut, 32'd9993);
        run(R, 4'b0010, 32'd0, 32'd2);
        check("r_slt", ALUOut, 32'd1);
        run(R, 4'b0101, 32'd16, 32'd2);
        check("r_srl", ALUOut, 32'd4);
        run(R, 4'b1101, 32'd8, 32'd1);
        check("r_sra", ALUOut, 32'd4);
        run(R, 4'b0001, 32'd2, 32'd2);
        check("r_sll", ALUOut, 32'd8);
        run(R, 4'b0100, 32'h55, 32'hFF);
        check("r_xor", ALUOut, 32'hAA);
        run(R, 4'b1000, 32'd0, 32'd1);
        check("r_sub_wrap", ALUOut, 32'hFFFF_FFFF);

        run(R, 4'b1101, 32'h8000_0000, 32'd4);
        check("sra_neg", ALUOut, 32'hF800_0000);
        run(R, 4'b0101, 32'h8000_0000, 32'd36);
        check("srl_shamt5", ALUOut, 32'h0800_0000);
        run(R, 4'b0010, 32'h8000_0000, 32'd1);
        check("slt_neg", ALUOut, 32'd1);
        run(R, 4'b0011, 32'h8000_0000, 32'd1);
        check("sltu_big", ALUOut, 32'd0);

        MEM_fwd1_reg = 1'b1;
        run(R, 4'b0000, 32'd1, 32'd1);
        check("fwd_mem", ALUOut, 32'd101);
        MEM_fwd1_reg = 1'b0;
        WB_fwd1_reg  = 1'b1;
        run(R, 4'b0000, 32'd1, 32'd1);
        check("fwd_wb", ALUOut, 32'd201);
        MEM_fwd1_reg = 1'b1;
        run(R, 4'b0000, 32'd1, 32'd1);
        check("fwd_both", ALUOut, 32'd101);
        MEM_fwd1_reg = 1'b0;
        WB_fwd1_reg  = 1'b0;
        WB_fwd2_reg  = 1'b1;
        run(R, 4'b1000, 32'd1, 32'd1);
        check("fwd_wb_b", ALUOut, 32'hFFFF_FF39);
        WB_fwd2_reg  = 1'b0;

        run(BRN, 4'b0000, 32'd7, 32'd7);
        check("beq_ctl", {25'd0, ALUCtl}, 32'h16);
        check("beq", {31'd0, Branch_Enable}, 32'd1);
        run(BRN, 4'b0001, 32'd7, 32'd7);
        check("bne", {31'd0, Branch_Enable}, 32'd0);
        run(BRN, 4'b0100, 32'hFFFF_FFFF, 32'd1);
        check("blt", {31'd0, Branch_Enable}, 32'd1);
        run(BRN, 4'b0110, 32'hFFFF_FFFF, 32'd1);
        check("bltu", {31'd0, Branch_Enable}, 32'd0);
        run(BRN, 4'b0111, 32'hFFFF_FFFF, 32'd1);
        check("bgeu", {31'd0, Branch_Enable}, 32'd1);
        run(BRN, 4'b0010, 32'd7, 32'd7);
        check("br_none", {31'd0, Branch_Enable}, 32'd0);
        run(R, 4'b0000, 32'd7, 32'd7);
        check("rtype_no_br", {31'd0, Branch_Enable}, 32'd0);

        run(LUI, 4'b0000, 32'd0, 32'h1234_5000);
        check("lui_ctl", {25'd0, ALUCtl}, 32'h0A);
        check("lui_out", ALUOut, 32'h1234_5000);
        run(I, 4'b1000, 32'd10, 32'd3);
        check("i_add_ctl", {25'd0, ALUCtl}, 32'h02);
        check("i_add_out", ALUOut, 32'd13);
        run(I, 4'b1101, 32'h8000_0000, 32'd4);
        check("i_sra_ctl", {25'd0, ALUCtl}, 32'h04);
        check("i_sra_out", ALUOut, 32'hF800_0000);
        run(7'b1111111, 4'b1000, 32'd2, 32'd3);
        check("undef_ctl", {25'd0, ALUCtl}, 32'h02);
        check("undef_out", ALUOut, 32'd5);

        A = 32'd40;
        B = 32'd2;
        #3;
        check("hold_between_edges", ALUOut, 32'd5);
        rst = 1'b0;
        #1;
        check("async_reset", ALUOut, 32'd0);
        @(posedge clk);
        #1;
        check("reset_held", ALUOut, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("after_rereset", ALUOut, 32'd42);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
